// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one shift per clock, valid/ready on both sides.
// Define BIN2BCD_SIGNED_EN for two's-complement input (magnitude + sign_out); otherwise unsigned.

module bin2bcd_add3 (
  input  logic [3:0] i_d,
  output logic [3:0] o_d
);
  assign o_d = (i_d >= 4'd5) ? i_d + 4'd3 : i_d;
endmodule

module bin2bcd_seq #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_in_valid,
  output logic                o_in_ready,
  input  logic [BIN_W-1:0]    i_bin_in,
  output logic                o_out_valid,
  input  logic                i_out_ready,
  output logic [4*DIGITS-1:0] o_bcd_out,
  output logic                o_sign_out,
  output logic                o_overflow
);
  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           r_state;
  logic [BIN_W-1:0] r_op;
  logic [BCD_W-1:0] r_acc;
  logic [BCD_W-1:0] r_bcd;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf_w;
  logic             r_ovf;
  logic             r_out_valid;

  logic [BCD_W-1:0] w_corr;
  logic [BCD_W-1:0] w_acc_nxt;
  logic [BIN_W-1:0] w_load;
  logic             w_carry;
  logic             w_last;

  // Per-digit add-3 correction; digits never carry into each other.
  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_dig
      bin2bcd_add3 u_add3 (.i_d(r_acc[4*g +: 4]), .o_d(w_corr[4*g +: 4]));
    end
  endgenerate

  assign w_carry   = w_corr[BCD_W-1];
  assign w_acc_nxt = {w_corr[BCD_W-2:0], r_op[BIN_W-1]};
  assign w_last    = (r_cnt == CNT_W'(BIN_W - 1));

`ifdef BIN2BCD_SIGNED_EN
  logic w_load_sign;
  logic r_sign_w;
  logic r_sign;

  assign w_load_sign = i_bin_in[BIN_W-1];
  // Negating the most negative value wraps to itself, which read unsigned is the right magnitude.
  assign w_load      = w_load_sign ? (~i_bin_in + BIN_W'(1)) : i_bin_in;
  assign o_sign_out  = r_sign;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sign_w <= 1'b0;
      r_sign   <= 1'b0;
    end else begin
      if (r_state == IDLE && i_in_valid) r_sign_w <= w_load_sign;
      if (r_state == SHIFT && w_last)    r_sign   <= r_sign_w;
    end
  end
`else
  assign w_load     = i_bin_in;
  assign o_sign_out = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_op        <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf_w     <= 1'b0;
      r_bcd       <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_in_valid) begin
            r_op    <= w_load;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf_w <= 1'b0;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_acc   <= w_acc_nxt;
          r_op    <= r_op << 1;
          r_ovf_w <= r_ovf_w | w_carry;
          r_cnt   <= r_cnt + CNT_W'(1);
          // Output registers load only here so they hold their value through IDLE and SHIFT.
          if (w_last) begin
            r_bcd       <= w_acc_nxt;
            r_ovf       <= r_ovf_w | w_carry;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_in_ready  = (r_state == IDLE);
  assign o_out_valid = r_out_valid;
  assign o_bcd_out   = r_bcd;
  assign o_overflow  = r_ovf;

endmodule
